// File: rtl/fft_power_accum.sv
// fft_power_accum: per-bin power (re^2 + im^2) of an FFT output stream, accumulated
// over 2**LOG2_AVG frames and streamed out bin by bin on a valid/ready interface.
// Optional feature macro: FFT_PWR_PEAK_EN adds a peak-bin tracker over the drained spectrum.
module fft_power_accum #(
    parameter int FFT_SIZE   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_AVG   = 2,
    localparam int BIN_W = $clog2(FFT_SIZE),
    localparam int POW_W = 2 * DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    fft_in_valid_i,
    input  logic [2*DATA_WIDTH-1:0] fft_in_data_i,
    output logic                    fft_in_ready_o,
    output logic                    pwr_valid_o,
    output logic [POW_W-1:0]        pwr_data_o,
    output logic [BIN_W-1:0]        pwr_bin_o,
    output logic                    pwr_last_o,
    input  logic                    pwr_ready_i,
    output logic                    peak_valid_o,
    output logic [BIN_W-1:0]        peak_bin_o,
    output logic [POW_W-1:0]        peak_pwr_o
);

    localparam int ACC_W = POW_W + LOG2_AVG;
    localparam int FC_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int AVG_N = 1 << LOG2_AVG;
    localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(FFT_SIZE - 1);
    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(AVG_N - 1);

    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

    state_t state, next_state;

    logic [BIN_W-1:0] bin_cnt;
    logic [BIN_W-1:0] drain_bin;
    logic [FC_W-1:0]  frame_cnt;
    logic             flush_cnt;
    logic             ready_q;
    logic             accept;
    logic             last_accept;
    logic             out_fire;

    logic signed [DATA_WIDTH-1:0] in_re;
    logic signed [DATA_WIDTH-1:0] in_im;

    logic                    s1_valid;
    logic                    s1_first;
    logic [BIN_W-1:0]        s1_bin;
    logic signed [POW_W-1:0] s1_rr;
    logic signed [POW_W-1:0] s1_ii;
    logic [POW_W-1:0]        power;

    logic [ACC_W-1:0] acc [FFT_SIZE];

    assign in_re          = fft_in_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign in_im          = fft_in_data_i[DATA_WIDTH-1:0];
    assign fft_in_ready_o = ready_q;
    assign accept         = fft_in_valid_i && ready_q && !clear_i;
    assign last_accept    = accept && (bin_cnt == LAST_BIN) && (frame_cnt == LAST_FRAME);
    assign out_fire       = pwr_valid_o && pwr_ready_i && !clear_i;

    // Both squares are non-negative, so their sum fits POW_W bits when read unsigned
    assign power = $unsigned(s1_rr) + $unsigned(s1_ii);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ACCUM;
        else         state <= next_state;
    end

    // Next-state logic; clear overrides every other event
    always_comb begin
        next_state = state;
        if (clear_i) begin
            next_state = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (last_accept) next_state = FLUSH;
                FLUSH:   if (flush_cnt) next_state = DRAIN;
                DRAIN:   if (out_fire && pwr_last_o) next_state = ACCUM;
                default: next_state = ACCUM;
            endcase
        end
    end

    // Output decode of the drain stream from state and the current drain bin
    always_comb begin
        pwr_valid_o = 1'b0;
        pwr_data_o  = '0;
        pwr_bin_o   = '0;
        pwr_last_o  = 1'b0;
        if (state == DRAIN) begin
            pwr_valid_o = 1'b1;
            pwr_data_o  = POW_W'(acc[drain_bin] >> LOG2_AVG);
            pwr_bin_o   = drain_bin;
            pwr_last_o  = (drain_bin == LAST_BIN);
        end
    end

    // Bin/frame/flush/drain counters and the registered input ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_cnt   <= '0;
            frame_cnt <= '0;
            flush_cnt <= 1'b0;
            drain_bin <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= (next_state == ACCUM);
            if (clear_i) begin
                bin_cnt   <= '0;
                frame_cnt <= '0;
                flush_cnt <= 1'b0;
                drain_bin <= '0;
            end else begin
                if (accept) begin
                    if (bin_cnt == LAST_BIN) begin
                        bin_cnt   <= '0;
                        frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
                    end else begin
                        bin_cnt <= bin_cnt + 1'b1;
                    end
                end
                flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
                if (out_fire) drain_bin <= pwr_last_o ? '0 : drain_bin + 1'b1;
            end
        end
    end

    // Stage 1: square both components and tag with bin and first-frame flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_bin   <= '0;
            s1_rr    <= '0;
            s1_ii    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= (frame_cnt == '0);
                s1_bin   <= bin_cnt;
                s1_rr    <= in_re * in_re;
                s1_ii    <= in_im * in_im;
            end
        end
    end

    // Stage 2: accumulate power; the first frame of a set overwrites the old sum
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FFT_SIZE; i++) acc[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < FFT_SIZE; i++) acc[i] <= '0;
        end else if (s1_valid) begin
            acc[s1_bin] <= (s1_first ? '0 : acc[s1_bin]) + ACC_W'(power);
        end
    end

`ifdef FFT_PWR_PEAK_EN
    logic [POW_W-1:0] best_pwr;
    logic [BIN_W-1:0] best_bin;
    logic [POW_W-1:0] cand_pwr;
    logic [BIN_W-1:0] cand_bin;
    logic             peak_valid_q;
    logic [BIN_W-1:0] peak_bin_q;
    logic [POW_W-1:0] peak_pwr_q;

    // Running maximum including the bin currently on the output; strict > keeps the lowest bin on ties
    always_comb begin
        cand_pwr = best_pwr;
        cand_bin = best_bin;
        if ((drain_bin == '0) || (pwr_data_o > best_pwr)) begin
            cand_pwr = pwr_data_o;
            cand_bin = drain_bin;
        end
    end

    // Peak tracker and held result, published the cycle after the last drain handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_pwr     <= '0;
            best_bin     <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_pwr_q   <= '0;
        end else if (clear_i) begin
            best_pwr     <= '0;
            best_bin     <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_pwr_q   <= '0;
        end else begin
            peak_valid_q <= 1'b0;
            if (out_fire) begin
                best_pwr <= cand_pwr;
                best_bin <= cand_bin;
                if (pwr_last_o) begin
                    peak_valid_q <= 1'b1;
                    peak_bin_q   <= cand_bin;
                    peak_pwr_q   <= cand_pwr;
                end
            end
        end
    end

    assign peak_valid_o = peak_valid_q;
    assign peak_bin_o   = peak_bin_q;
    assign peak_pwr_o   = peak_pwr_q;
`else
    assign peak_valid_o = 1'b0;
    assign peak_bin_o   = '0;
    assign peak_pwr_o   = '0;
`endif

endmodule

// File: tb/tb_fft_power_accum.sv
// tb_fft_power_accum: randomized frames fed into fft_power_accum; drained spectra are
// compared against an averaged-power reference computed directly from the sample tables.
module tb_fft_power_accum;

    localparam int N   = 16;
    localparam int DW  = 16;
    localparam int L   = 2;
    localparam int AVG = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          fft_in_valid_i;
    logic [2*DW-1:0] fft_in_data_i;
    logic          fft_in_ready_o;
    logic          pwr_valid_o;
    logic [2*DW-1:0] pwr_data_o;
    logic [3:0]    pwr_bin_o;
    logic          pwr_last_o;
    logic          pwr_ready_i;
    logic          peak_valid_o;
    logic [3:0]    peak_bin_o;
    logic [2*DW-1:0] peak_pwr_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] re_tab [AVG][N];
    logic [DW-1:0] im_tab [AVG][N];
    longint        exp_pwr [N];

    fft_power_accum #(.FFT_SIZE(N), .DATA_WIDTH(DW), .LOG2_AVG(L)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .fft_in_valid_i (fft_in_valid_i),
        .fft_in_data_i  (fft_in_data_i),
        .fft_in_ready_o (fft_in_ready_o),
        .pwr_valid_o    (pwr_valid_o),
        .pwr_data_o     (pwr_data_o),
        .pwr_bin_o      (pwr_bin_o),
        .pwr_last_o     (pwr_last_o),
        .pwr_ready_i    (pwr_ready_i),
        .peak_valid_o   (peak_valid_o),
        .peak_bin_o     (peak_bin_o),
        .peak_pwr_o     (peak_pwr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic longint sq(input logic [DW-1:0] v);
        longint s;
        s = longint'($signed(v));
        return s * s;
    endfunction

    // Averaged power per bin, straight from the sample tables
    task automatic buildExpect();
        for (int k = 0; k < N; k++) begin
            longint s;
            s = 0;
            for (int f = 0; f < AVG; f++) s += sq(re_tab[f][k]) + sq(im_tab[f][k]);
            exp_pwr[k] = s / AVG;
        end
    endtask

    task automatic pushSample(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int w;
        w = 0;
        fft_in_valid_i = 1'b1;
        fft_in_data_i  = {re, im};
        while (!fft_in_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        if (!fft_in_ready_o) begin
            checkOutput("in_ready_timeout", 64'(fft_in_ready_o), 64'd1);
            fft_in_valid_i = 1'b0;
        end else begin
            @(negedge clk_i);
            fft_in_valid_i = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit gaps);
        for (int f = 0; f < AVG; f++) begin
            for (int k = 0; k < N; k++) begin
                if (gaps && $urandom_range(0, 3) == 0) @(negedge clk_i);
                pushSample(re_tab[f][k], im_tab[f][k]);
            end
        end
        buildExpect();
    endtask

    task automatic fillRandom();
        for (int f = 0; f < AVG; f++)
            for (int k = 0; k < N; k++) begin
                re_tab[f][k] = DW'($urandom);
                im_tab[f][k] = DW'($urandom);
            end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (!pwr_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("drain_start", 64'(pwr_valid_o), 64'd1);
    endtask

    task automatic collectDrain(input bit random_ready, input bit junk_in);
        int got, cycles, wait_cnt;
        logic [2*DW-1:0] held_data;
        logic [3:0] held_bin;
        bit stalled;
        longint best;
        int best_bin;
        got = 0; cycles = 0; wait_cnt = 0; stalled = 0;
        held_data = '0; held_bin = '0;
        while (!pwr_valid_o && wait_cnt < 20) begin
            checkOutput("flush_ready", 64'(fft_in_ready_o), 64'd0);
            if (junk_in) begin
                fft_in_valid_i = 1'b1;
                fft_in_data_i  = $urandom;
            end
            @(negedge clk_i);
            wait_cnt++;
        end
        checkOutput("flush_latency", 64'(wait_cnt), 64'd2);
        while (got < N && cycles < 1000) begin
            if (!pwr_valid_o) begin
                checkOutput("drain_valid", 64'(pwr_valid_o), 64'd1);
                break;
            end
            if (junk_in) begin
                fft_in_valid_i = 1'b1;
                fft_in_data_i  = $urandom;
            end
            pwr_ready_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            checkOutput("drain_in_ready", 64'(fft_in_ready_o), 64'd0);
            checkOutput("peak_quiet", 64'(peak_valid_o), 64'd0);
            if (stalled) begin
                checkOutput("stall_data", 64'(pwr_data_o), 64'(held_data));
                checkOutput("stall_bin", 64'(pwr_bin_o), 64'(held_bin));
            end
            if (pwr_ready_i) begin
                checkOutput("drain_bin", 64'(pwr_bin_o), 64'(got));
                checkOutput("drain_data", 64'(pwr_data_o), 64'(exp_pwr[got]));
                checkOutput("drain_last", 64'(pwr_last_o), 64'(got == N - 1));
                got++;
                stalled = 0;
            end else begin
                stalled   = 1;
                held_data = pwr_data_o;
                held_bin  = pwr_bin_o;
            end
            @(negedge clk_i);
            cycles++;
        end
        fft_in_valid_i = 1'b0;
        pwr_ready_i    = 1'b0;
        checkOutput("drain_count", 64'(got), 64'(N));
        checkOutput("post_valid", 64'(pwr_valid_o), 64'd0);
        checkOutput("post_ready", 64'(fft_in_ready_o), 64'd1);
        best = exp_pwr[0];
        best_bin = 0;
        for (int k = 1; k < N; k++) if (exp_pwr[k] > best) begin
            best = exp_pwr[k];
            best_bin = k;
        end
`ifdef FFT_PWR_PEAK_EN
        checkOutput("peak_pulse", 64'(peak_valid_o), 64'd1);
        checkOutput("peak_bin", 64'(peak_bin_o), 64'(best_bin));
        checkOutput("peak_pwr", 64'(peak_pwr_o), 64'(best));
        @(negedge clk_i);
        checkOutput("peak_once", 64'(peak_valid_o), 64'd0);
        checkOutput("peak_hold", 64'(peak_pwr_o), 64'(best));
`else
        checkOutput("peak_off", {27'd0, peak_valid_o, peak_bin_o, peak_pwr_o}, 64'd0);
`endif
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; fft_in_valid_i = 1'b0; fft_in_data_i = '0; pwr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_ctrl", {60'd0, fft_in_ready_o, pwr_valid_o, pwr_last_o, peak_valid_o}, 64'd0);
        checkOutput("rst_data", {pwr_data_o, peak_pwr_o}, 64'd0);
        checkOutput("rst_bins", {56'd0, pwr_bin_o, peak_bin_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("ready_after_reset", 64'(fft_in_ready_o), 64'd1);

        // Constant 0x0100 real part on every bin
        for (int f = 0; f < AVG; f++) for (int k = 0; k < N; k++) begin
            re_tab[f][k] = 16'h0100; im_tab[f][k] = 16'h0000;
        end
        applyStimulus(0);
        collectDrain(0, 0);

        // Most negative input on both parts
        for (int f = 0; f < AVG; f++) for (int k = 0; k < N; k++) begin
            re_tab[f][k] = 16'h8000; im_tab[f][k] = 16'h8000;
        end
        applyStimulus(0);
        collectDrain(0, 0);

        // Small values whose average is fractional
        for (int f = 0; f < AVG; f++) for (int k = 0; k < N; k++) begin
            re_tab[f][k] = DW'(k); im_tab[f][k] = DW'(f);
        end
        applyStimulus(1);
        collectDrain(0, 0);

        // Random data, random downstream stalls, junk input offered during drain
        for (int r = 0; r < 2; r++) begin
            fillRandom();
            applyStimulus(1);
            collectDrain(1, 1);
        end

        // Clear arriving with bin 7 of frame 2, then four clean frames
        for (int i = 0; i < 2 * N + 7; i++) pushSample(DW'($urandom), DW'($urandom));
        clear_i = 1'b1; fft_in_valid_i = 1'b1; fft_in_data_i = $urandom;
        @(negedge clk_i);
        clear_i = 1'b0; fft_in_valid_i = 1'b0;
        checkOutput("clear_ready", 64'(fft_in_ready_o), 64'd1);
        fillRandom();
        applyStimulus(1);
        collectDrain(1, 0);

        // Clear in the middle of a drain
        fillRandom();
        applyStimulus(0);
        waitDrain();
        pwr_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        pwr_ready_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checkOutput("clear_drain_valid", 64'(pwr_valid_o), 64'd0);
        checkOutput("clear_drain_ready", 64'(fft_in_ready_o), 64'd1);
        checkOutput("clear_peak", {27'd0, peak_valid_o, peak_bin_o, peak_pwr_o}, 64'd0);
        fillRandom();
        applyStimulus(1);
        collectDrain(1, 0);

        // Reset in the middle of a drain
        fillRandom();
        applyStimulus(0);
        waitDrain();
        pwr_ready_i = 1'b1;
        repeat (5) @(negedge clk_i);
        pwr_ready_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("mid_rst_ctrl", {60'd0, fft_in_ready_o, pwr_valid_o, pwr_last_o, peak_valid_o}, 64'd0);
        checkOutput("mid_rst_data", {pwr_data_o, peak_pwr_o}, 64'd0);
        checkOutput("mid_rst_bins", {56'd0, pwr_bin_o, peak_bin_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("mid_rst_ready", 64'(fft_in_ready_o), 64'd1);
        fillRandom();
        applyStimulus(1);
        collectDrain(1, 0);

        // One dominant bin
        for (int f = 0; f < AVG; f++) for (int k = 0; k < N; k++) begin
            re_tab[f][k] = (k == 5) ? 16'd1000 : 16'd10; im_tab[f][k] = 16'd0;
        end
        applyStimulus(0);
        collectDrain(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
